shift_unit: RTL and testbench

//  Multicycle shift/rotate unit for the datapath: selects the shift amount from NSRC sources
//  (e.g. shamt field, MDR, B), captures the operand on start, then shifts STEP bits per cycle.

---
 rtl/shift_unit_pkg.sv | 32 +++
 rtl/shift_amt_select.sv | 28 ++
 rtl/shift_unit.sv | 120 ++++++++++++
 tb/tb_shift_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_unit_pkg.sv
// Shared definitions for the multicycle shift/rotate unit.
// Holds the op codes, the FSM state encoding and the op-code decoder.
package shift_unit_pkg;

  typedef enum logic [2:0] {
    SH_LOAD = 3'b000,
    SH_SLL  = 3'b001,
    SH_SRL  = 3'b010,
    SH_SRA  = 3'b011,
    SH_ROR  = 3'b100,
    SH_ROL  = 3'b101
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Codes 110 and 111 have no op of their own and behave as LOAD.
  function automatic shift_op_e decode_op(input logic [2:0] code);
    case (code)
      3'b001:  return SH_SLL;
      3'b010:  return SH_SRL;
      3'b011:  return SH_SRA;
      3'b100:  return SH_ROR;
      3'b101:  return SH_ROL;
      default: return SH_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/shift_amt_select.sv
// Combinational N-way shift-amount mux.
// It keeps only the low AMT_W bits of the selected source. An out-of-range select gives 0.
module shift_amt_select
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [NSRC*WIDTH-1:0] i_src,
  output logic [AMT_W-1:0]      o_amt
);

  // The upper bits of each source are ignored on purpose.
  logic w_unused_hi;
  assign w_unused_hi = ^i_src;

  // NOTE: default first so no select value can infer a latch.
  always_comb begin
    o_amt = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_sel == SEL_W'(i)) o_amt = i_src[i*WIDTH +: AMT_W];
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shift/rotate unit with a start/busy/done handshake.
// It captures the operand on start and then shifts by up to STEP bits per cycle until the amount is used up.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            shift_op,
  input  logic [SEL_W-1:0]      amt_sel,
  input  logic [NSRC*WIDTH-1:0] amt_src,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int REM_W = AMT_W + 1;
  localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

  state_e           r_state;
  shift_op_e        r_op;
  logic [REM_W-1:0] r_rem;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_done;

  logic [AMT_W-1:0] w_amt_raw;
  logic [AMT_W-1:0] w_amt;
  shift_op_e        w_op;
  logic [REM_W-1:0] w_step_amt;
  logic [WIDTH-1:0] w_shifted;

  shift_amt_select #(.WIDTH(WIDTH), .NSRC(NSRC)) u_amt_select (
    .i_sel (amt_sel),
    .i_src (amt_src),
    .o_amt (w_amt_raw)
  );

  assign w_op  = decode_op(shift_op);
  assign w_amt = (w_op == SH_LOAD) ? '0 : w_amt_raw;

  // The final step may be shorter than STEP when the amount is not a multiple of it.
  assign w_step_amt = (r_rem < STEP_R) ? r_rem : STEP_R;

  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] d,
                                                input shift_op_e        op,
                                                input logic [REM_W-1:0] s);
    logic [REM_W-1:0] inv;
    inv = REM_W'(WIDTH) - s;
    case (op)
      SH_SLL:  return d << s;
      SH_SRL:  return d >> s;
      SH_SRA:  return $signed(d) >>> s;
      SH_ROR:  return (d >> s) | (d << inv);
      SH_ROL:  return (d << s) | (d >> inv);
      default: return d;
    endcase
  endfunction

  assign w_shifted = shift_fn(r_data, r_op, w_step_amt);

  // busy/done are registered next to the state so the control FSM sees clean levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= SH_LOAD;
      r_rem   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_data <= data_in;
            r_op   <= w_op;
            r_rem  <= {1'b0, w_amt};
            if (w_amt == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= r_rem - w_step_amt;
          if (r_rem <= STEP_R) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit. A STEP=1 and a STEP=4 instance share the same stimulus.
// Each scenario task checks the instance it targets against hand-computed values.
module tb_shift_unit;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  shift_op;
  logic [1:0]  amt_sel;
  logic [95:0] amt_src;
  logic [31:0] data_in;

  logic [31:0] d1_out, d4_out;
  logic        d1_busy, d4_busy, d1_done, d4_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(32), .NSRC(3), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op), .amt_sel(amt_sel),
    .amt_src(amt_src), .data_in(data_in), .data_out(d1_out), .busy(d1_busy), .done(d1_done)
  );

  shift_unit #(.WIDTH(32), .NSRC(3), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op), .amt_sel(amt_sel),
    .amt_src(amt_src), .data_in(data_in), .data_out(d4_out), .busy(d4_busy), .done(d4_done)
  );

  task automatic set_src(input int idx, input logic [31:0] val);
    amt_src[idx*32 +: 32] = val;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Start is raised for one cycle, which is cycle 0 of the operation.
  task automatic issue(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    shift_op = op;
    amt_sel  = sel;
    data_in  = d;
    start    = 1'b1;
  endtask

  // Each negedge after the start is cycle c. done_cyc stays -1 if the budget runs out.
  task automatic wait_done(input int which, input int budget, output int done_cyc,
                           output int busy_cyc, output logic [31:0] result);
    done_cyc = -1;
    busy_cyc = 0;
    result   = 'x;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if ((which == 1) ? d1_busy : d4_busy) busy_cyc++;
      if ((which == 1) ? d1_done : d4_done) begin
        done_cyc = c;
        result   = (which == 1) ? d1_out : d4_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    shift_op = OP_LOAD;
    amt_sel  = '0;
    amt_src  = '0;
    data_in  = '0;
    #2;
    n_checks++;
    if ({d1_out, d1_busy, d1_done} !== 34'd0)
      $display("FAIL reset_dut1: got out=%h busy=%b done=%b, want 0/0/0", d1_out, d1_busy, d1_done);
    else n_pass++;
    n_checks++;
    if ({d4_out, d4_busy, d4_done} !== 34'd0)
      $display("FAIL reset_dut4: got out=%h busy=%b done=%b, want 0/0/0", d4_out, d4_busy, d4_done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_sll();
    int dc, bc;
    logic [31:0] res;
    set_src(0, 32'd4);
    issue(OP_SLL, 2'd0, 32'h0000_0001);
    wait_done(1, 40, dc, bc, res);
    n_checks++;
    if (dc !== 5) $display("FAIL sll_done_cycle: got %0d, want 5", dc); else n_pass++;
    n_checks++;
    if (bc !== 4) $display("FAIL sll_busy_cycles: got %0d, want 4", bc); else n_pass++;
    n_checks++;
    if (res !== 32'h0000_0010) $display("FAIL sll_result: got %h, want 00000010", res); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (d1_out !== 32'h0000_0010 || d1_done !== 1'b0)
      $display("FAIL sll_hold: got out=%h done=%b, want 00000010/0", d1_out, d1_done);
    else n_pass++;
  endtask

  task automatic test_sra();
    int dc, bc;
    logic [31:0] res;
    set_src(2, 32'hFFFF_FFFF);
    issue(OP_SRA, 2'd2, 32'h8000_0000);
    wait_done(1, 60, dc, bc, res);
    n_checks++;
    if (dc !== 32) $display("FAIL sra_done_cycle: got %0d, want 32", dc); else n_pass++;
    n_checks++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL sra_result: got %h, want ffffffff", res); else n_pass++;
  endtask

  task automatic test_rotate_step4();
    int dc, bc;
    logic [31:0] res;
    set_src(1, 32'd4);
    issue(OP_ROR, 2'd1, 32'h0000_00F1);
    wait_done(4, 20, dc, bc, res);
    n_checks++;
    if (dc !== 2) $display("FAIL ror4_done_cycle: got %0d, want 2", dc); else n_pass++;
    n_checks++;
    if (res !== 32'h1000_000F) $display("FAIL ror4_result: got %h, want 1000000f", res); else n_pass++;
    idle(40);
    set_src(1, 32'd5);
    issue(OP_ROL, 2'd1, 32'h8000_0001);
    wait_done(4, 20, dc, bc, res);
    n_checks++;
    if (dc !== 3) $display("FAIL rol5_done_cycle: got %0d, want 3", dc); else n_pass++;
    n_checks++;
    if (res !== 32'h0000_0030) $display("FAIL rol5_result: got %h, want 00000030", res); else n_pass++;
    idle(40);
    set_src(0, 32'd7);
    issue(OP_SRL, 2'd0, 32'h8000_0000);
    wait_done(4, 20, dc, bc, res);
    n_checks++;
    if (dc !== 3) $display("FAIL srl7_done_cycle: got %0d, want 3", dc); else n_pass++;
    n_checks++;
    if (res !== 32'h0100_0000) $display("FAIL srl7_result: got %h, want 01000000", res); else n_pass++;
    idle(40);
  endtask

  task automatic test_zero_amount();
    int dc, bc;
    logic [31:0] res;
    issue(OP_SRL, 2'd3, 32'hDEAD_BEEF);
    wait_done(1, 10, dc, bc, res);
    n_checks++;
    if (dc !== 1 || bc !== 0)
      $display("FAIL sel_oob_timing: got done=%0d busy=%0d, want 1/0", dc, bc);
    else n_pass++;
    n_checks++;
    if (res !== 32'hDEAD_BEEF) $display("FAIL sel_oob_result: got %h, want deadbeef", res); else n_pass++;
    set_src(0, 32'd4);
    issue(OP_LOAD, 2'd0, 32'hCAFE_F00D);
    wait_done(1, 10, dc, bc, res);
    n_checks++;
    if (dc !== 1 || res !== 32'hCAFE_F00D)
      $display("FAIL load: got done=%0d out=%h, want 1/cafef00d", dc, res);
    else n_pass++;
    issue(3'b111, 2'd0, 32'h0BAD_C0DE);
    wait_done(1, 10, dc, bc, res);
    n_checks++;
    if (dc !== 1 || res !== 32'h0BAD_C0DE)
      $display("FAIL op111_load: got done=%0d out=%h, want 1/0badc0de", dc, res);
    else n_pass++;
    idle(4);
  endtask

  task automatic test_back_to_back();
    int dc = -1;
    logic [31:0] res = 'x;
    logic busy_c4 = 1'b0;
    set_src(0, 32'd8);
    issue(OP_SLL, 2'd0, 32'h0000_0001);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin
        data_in = 32'hFFFF_FFFF;
        set_src(0, 32'd1);
      end
      if (c == 4) busy_c4 = d1_busy;
      if (d1_done) begin
        dc  = c;
        res = d1_out;
        shift_op = OP_LOAD;
        data_in  = 32'h1234_5678;
        start    = 1'b1;
        break;
      end
    end
    n_checks++;
    if (busy_c4 !== 1'b1) $display("FAIL b2b_busy_hold: got %b, want 1", busy_c4); else n_pass++;
    n_checks++;
    if (dc !== 9) $display("FAIL b2b_done_cycle: got %0d, want 9", dc); else n_pass++;
    n_checks++;
    if (res !== 32'h0000_0100) $display("FAIL b2b_result: got %h, want 00000100", res); else n_pass++;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (d1_done !== 1'b1 || d1_busy !== 1'b0 || d1_out !== 32'h1234_5678)
      $display("FAIL b2b_restart: got done=%b busy=%b out=%h, want 1/0/12345678",
               d1_done, d1_busy, d1_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (d1_done !== 1'b0) $display("FAIL b2b_done_pulse: got %b, want 0", d1_done); else n_pass++;
    idle(4);
  endtask

  task automatic test_reset_abort();
    int dc, bc;
    int done_seen = 0;
    logic [31:0] res;
    set_src(0, 32'd10);
    issue(OP_SRL, 2'd0, 32'hFFFF_0000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_busy !== 1'b1) $display("FAIL abort_pre_busy: got %b, want 1", d1_busy); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (d1_out !== 32'd0 || d1_busy !== 1'b0 || d1_done !== 1'b0)
      $display("FAIL abort_reset: got out=%h busy=%b done=%b, want 0/0/0", d1_out, d1_busy, d1_done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (d1_done) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) $display("FAIL abort_no_done: got %0d done cycles, want 0", done_seen);
    else n_pass++;
    set_src(0, 32'd4);
    issue(OP_SLL, 2'd0, 32'h0000_0001);
    wait_done(1, 40, dc, bc, res);
    n_checks++;
    if (dc !== 5 || res !== 32'h0000_0010)
      $display("FAIL abort_next_op: got done=%0d out=%h, want 5/00000010", dc, res);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sll();
    idle(40);
    test_sra();
    idle(40);
    test_rotate_step4();
    test_zero_amount();
    test_back_to_back();
    idle(40);
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog expired");
  end

endmodule
